// File: rtl/micro_ctrl_seq.sv
// Microprogrammed control sequencer for the multicycle MIPS datapath.
// A 4-bit micro-PC walks a fixed 16-entry microcode ROM; opcode dispatch picks branch targets.
module micro_ctrl_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] upc,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_RSV12  = 4'd12,
    S_RSV13  = 4'd13,
    S_RSV14  = 4'd14,
    S_RSV15  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } uword_t;

  state_e upc_q, upc_d;
  logic   illegal_q, illegal_d;
  uword_t rom_word;
  uword_t out_word;
  state_e disp1_target, disp2_target;
  logic   disp1_illegal, disp2_illegal;
  logic   mem_state;
  logic   mem_stall;
  logic   done_raw;

  // Microcode ROM: one control word per micro-address.
  always_comb begin
    rom_word = '0;
    case (upc_q)
      S_FETCH: begin
        rom_word.mem_read  = 1'b1;
        rom_word.ir_write  = 1'b1;
        rom_word.pc_write  = 1'b1;
        rom_word.alu_src_b = 2'b01;
      end
      S_DECODE: rom_word.alu_src_b = 2'b11;
      S_MEMADR: begin
        rom_word.alu_src_a = 1'b1;
        rom_word.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        rom_word.mem_read = 1'b1;
        rom_word.iord     = 1'b1;
      end
      S_MEMWB: begin
        rom_word.reg_write = 1'b1;
        rom_word.memto_reg = 1'b1;
        rom_word.reg_dst   = 1'b0;
      end
      S_MEMWR: begin
        rom_word.mem_write = 1'b1;
        rom_word.iord      = 1'b1;
      end
      S_REXEC: begin
        rom_word.alu_src_a = 1'b1;
        rom_word.alu_op    = 2'b10;
      end
      S_RWB: begin
        rom_word.reg_write = 1'b1;
        rom_word.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        rom_word.alu_src_a     = 1'b1;
        rom_word.alu_op        = 2'b01;
        rom_word.pc_write_cond = 1'b1;
        rom_word.pc_source     = 2'b01;
      end
      S_JUMP: begin
        rom_word.pc_write  = 1'b1;
        rom_word.pc_source = 2'b10;
      end
      S_ADDIEX: begin
        rom_word.alu_src_a = 1'b1;
        rom_word.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        rom_word.reg_write = 1'b1;
        rom_word.reg_dst   = 1'b0;
      end
      default: rom_word = '0;
    endcase
  end

  // Dispatch tables; an unknown opcode sends the sequencer back to FETCH.
  always_comb begin
    disp1_target  = S_FETCH;
    disp1_illegal = 1'b0;
    case (op)
      OP_RTYPE:     disp1_target = S_REXEC;
      OP_LW, OP_SW: disp1_target = S_MEMADR;
      OP_BEQ:       disp1_target = S_BEQ;
      OP_J:         disp1_target = S_JUMP;
      OP_ADDI:      disp1_target = S_ADDIEX;
      default:      disp1_illegal = 1'b1;
    endcase
  end

  always_comb begin
    disp2_target  = S_FETCH;
    disp2_illegal = 1'b0;
    case (op)
      OP_LW:   disp2_target = S_MEMRD;
      OP_SW:   disp2_target = S_MEMWR;
      default: disp2_illegal = 1'b1;
    endcase
  end

  // mem_ready is the ready half of a handshake: a memory state offers its access every
  // cycle, and only the edge ending a cycle with mem_ready=1 advances upc or commits writes.
  assign mem_state = (upc_q == S_FETCH) || (upc_q == S_MEMRD) || (upc_q == S_MEMWR);
  assign mem_stall = mem_state && !mem_ready;

  always_comb begin
    upc_d     = S_FETCH;
    illegal_d = 1'b0;
    case (upc_q)
      S_FETCH:  upc_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        upc_d     = disp1_target;
        illegal_d = disp1_illegal;
      end
      S_MEMADR: begin
        upc_d     = disp2_target;
        illegal_d = disp2_illegal;
      end
      S_MEMRD:  upc_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  upc_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  upc_d = S_RWB;
      S_ADDIEX: upc_d = S_ADDIWB;
      default:  upc_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      upc_q     <= upc_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    done_raw = 1'b0;
    case (upc_q)
      S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: done_raw = 1'b1;
      S_MEMWR:  done_raw = mem_ready;
      S_DECODE: done_raw = disp1_illegal;
      S_MEMADR: done_raw = disp2_illegal;
      default:  done_raw = 1'b0;
    endcase
  end

  // A stalled memory state must not commit state; reset silences every control line.
  always_comb begin
    out_word = rom_word;
    if (mem_stall) begin
      out_word.pc_write      = 1'b0;
      out_word.pc_write_cond = 1'b0;
      out_word.ir_write      = 1'b0;
      out_word.reg_write     = 1'b0;
    end
    if (rst) begin
      out_word = '0;
    end
  end

  assign PCWrite     = out_word.pc_write;
  assign PCWriteCond = out_word.pc_write_cond;
  assign IorD        = out_word.iord;
  assign MemRead     = out_word.mem_read;
  assign MemWrite    = out_word.mem_write;
  assign IRWrite     = out_word.ir_write;
  assign MemtoReg    = out_word.memto_reg;
  assign ALUSrcA     = out_word.alu_src_a;
  assign RegWrite    = out_word.reg_write;
  assign RegDst      = out_word.reg_dst;
  assign PCSource    = out_word.pc_source;
  assign ALUOp       = out_word.alu_op;
  assign ALUSrcB     = out_word.alu_src_b;
  assign upc         = upc_q;
  assign instr_done  = done_raw && !rst;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_micro_ctrl_seq.sv
// Directed bench for micro_ctrl_seq: each scenario walks a table of per-cycle inputs
// with hand-derived upc and control-word expectations.
module tb_micro_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] upc;
  logic       instr_done, illegal_op;

  int n_pass  = 0;
  int n_total = 0;

  micro_ctrl_seq dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .upc(upc), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB}
  logic [15:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

  localparam logic [15:0] W_ZERO   = 16'h0000;
  localparam logic [15:0] W_FETCH  = 16'h9401;
  localparam logic [15:0] W_FWAIT  = 16'h1001;
  localparam logic [15:0] W_DECODE = 16'h0003;
  localparam logic [15:0] W_MEMADR = 16'h0102;
  localparam logic [15:0] W_MEMRD  = 16'h3000;
  localparam logic [15:0] W_MEMWB  = 16'h0280;
  localparam logic [15:0] W_MEMWR  = 16'h2800;
  localparam logic [15:0] W_REXEC  = 16'h0108;
  localparam logic [15:0] W_RWB    = 16'h00C0;
  localparam logic [15:0] W_BEQ    = 16'h4114;
  localparam logic [15:0] W_JUMP   = 16'h8020;
  localparam logic [15:0] W_ADDIEX = 16'h0102;
  localparam logic [15:0] W_ADDIWB = 16'h0080;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // One table row: inputs for the cycle, expected upc, expected {ctl, instr_done, illegal_op}.
  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  upc;
    logic [17:0] w;
  } vec_t;

  task automatic test_reset();
    vec_t tv[$];
    rst = 1'b1; mem_ready = 1'b1; op = OP_J;
    @(posedge clk); #1;
    tv.push_back({1'b1, 1'b1, OP_J, 4'd0, W_ZERO,   2'b00});
    tv.push_back({1'b1, 1'b1, OP_J, 4'd0, W_ZERO,   2'b00});
    tv.push_back({1'b0, 1'b0, OP_J, 4'd0, W_FWAIT,  2'b00});
    tv.push_back({1'b0, 1'b0, OP_J, 4'd0, W_FWAIT,  2'b00});
    tv.push_back({1'b0, 1'b0, OP_J, 4'd0, W_FWAIT,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_J, 4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_J, 4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_J, 4'd9, W_JUMP,   2'b10});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL reset upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL reset outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    vec_t tv[$];
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd2, W_MEMADR, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd3, W_MEMRD,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd4, W_MEMWB,  2'b10});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL lw upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL lw outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    vec_t tv[$];
    tv.push_back({1'b0, 1'b1, OP_R, 4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_R, 4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_R, 4'd6, W_REXEC,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_R, 4'd7, W_RWB,    2'b10});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL rtype upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL rtype outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_j();
    vec_t tv[$];
    tv.push_back({1'b0, 1'b1, OP_ADDI, 4'd0,  W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_ADDI, 4'd1,  W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_ADDI, 4'd10, W_ADDIEX, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_ADDI, 4'd11, W_ADDIWB, 2'b10});
    tv.push_back({1'b0, 1'b1, OP_J,    4'd0,  W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,    4'd1,  W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,    4'd9,  W_JUMP,   2'b10});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL addi_j upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL addi_j outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv[$];
    tv.push_back({1'b0, 1'b1, OP_SW,  4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_SW,  4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_SW,  4'd2, W_MEMADR, 2'b00});
    tv.push_back({1'b0, 1'b0, OP_SW,  4'd5, W_MEMWR,  2'b00});
    tv.push_back({1'b0, 1'b0, OP_SW,  4'd5, W_MEMWR,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_SW,  4'd5, W_MEMWR,  2'b10});
    tv.push_back({1'b0, 1'b1, OP_BEQ, 4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_BEQ, 4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_BEQ, 4'd8, W_BEQ,    2'b10});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL sw_beq upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL sw_beq outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    vec_t tv[$];
    tv.push_back({1'b0, 1'b1, OP_BAD, 4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_BAD, 4'd1, W_DECODE, 2'b10});
    tv.push_back({1'b0, 1'b1, OP_J,   4'd0, W_FETCH,  2'b01});
    tv.push_back({1'b0, 1'b1, OP_J,   4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,   4'd9, W_JUMP,   2'b10});
    // opcode that is legal at DECODE but not at MEMADR
    tv.push_back({1'b0, 1'b1, OP_LW,  4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW,  4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_BEQ, 4'd2, W_MEMADR, 2'b10});
    tv.push_back({1'b0, 1'b1, OP_J,   4'd0, W_FETCH,  2'b01});
    tv.push_back({1'b0, 1'b1, OP_J,   4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,   4'd9, W_JUMP,   2'b10});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL illegal upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL illegal outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    vec_t tv[$];
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_LW, 4'd2, W_MEMADR, 2'b00});
    tv.push_back({1'b0, 1'b0, OP_LW, 4'd3, W_MEMRD,  2'b00});
    tv.push_back({1'b1, 1'b0, OP_LW, 4'd3, W_ZERO,   2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,  4'd0, W_FETCH,  2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,  4'd1, W_DECODE, 2'b00});
    tv.push_back({1'b0, 1'b1, OP_J,  4'd9, W_JUMP,   2'b10});
    tv.push_back({1'b0, 1'b1, OP_J,  4'd0, W_FETCH,  2'b00});
    foreach (tv[i]) begin
      rst = tv[i].rst; mem_ready = tv[i].mr; op = tv[i].op;
      #1;
      n_total++;
      if (upc !== tv[i].upc) $display("FAIL reset_mid upc step %0d: got %0d want %0d", i, upc, tv[i].upc);
      else n_pass++;
      n_total++;
      if ({ctl, instr_done, illegal_op} !== tv[i].w)
        $display("FAIL reset_mid outputs step %0d: got %h want %h", i, {ctl, instr_done, illegal_op}, tv[i].w);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    op = OP_R;
    test_reset();
    test_lw();
    test_rtype();
    test_addi_j();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/micro_ctrl_seq.md
# micro_ctrl_seq

Microprogrammed control sequencer for the multicycle MIPS datapath. A 4-bit micro-PC indexes a 16-entry microcode ROM. Dispatch tables, keyed on the instruction opcode, select the next micro-address. The block drives every datapath control line, including `RegDst`, which is the select input of the 5-bit write-register mux that chooses rt or rd.

## Interface
No parameters. The microcode is fixed.
- `clk` input 1: the single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op` input 6: opcode, IR[31:26]. Stable from DECODE until the instruction retires.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst` output 1 each: datapath controls.
- `PCSource`, `ALUOp`, `ALUSrcB` output 2 each: datapath controls.
- `upc` output 4: current micro-PC.
- `instr_done` output 1: the current cycle is the last cycle of an instruction.
- `illegal_op` output 1: registered, one-cycle pulse for an unsupported opcode.

## Operation
- The micro-PC register is `upc`. Control outputs are a combinational decode of `upc` (Moore).
- While `rst`=1, all control outputs and `instr_done` are forced to 0.
- Microwords are listed below. Unlisted signals are 0.
  - 0 FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01. Next state is 1.
  - 1 DECODE: ALUSrcB=11. Next state comes from dispatch-1.
  - 2 MEMADR: ALUSrcA, ALUSrcB=10. Next state comes from dispatch-2.
  - 3 MEMRD: MemRead, IorD. Next state is 4.
  - 4 MEMWB: RegWrite, MemtoReg, RegDst=0. Next state is 0.
  - 5 MEMWR: MemWrite, IorD. Next state is 0.
  - 6 REXEC: ALUSrcA, ALUOp=10. Next state is 7.
  - 7 RWB: RegWrite, RegDst=1. Next state is 0.
  - 8 BEQ: ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01. Next state is 0.
  - 9 JUMP: PCWrite, PCSource=10. Next state is 0.
  - 10 ADDIEX: ALUSrcA, ALUSrcB=10. Next state is 11.
  - 11 ADDIWB: RegWrite, RegDst=0. Next state is 0.
  - 12–15: all outputs 0. Next state is 0.
- Dispatch-1 (applies in state 1):
  - R-type 000000 → 6
  - lw 100011 and sw 101011 → 2
  - beq 000100 → 8
  - j 000010 → 9
  - addi 001000 → 10
  - any other opcode → 0, and `illegal_op` is set for the next cycle.
- Dispatch-2 (applies in state 2):
  - lw → 3
  - sw → 5
  - any other opcode → 0, and `illegal_op` is set.
- Memory wait: states 0, 3 and 5 are memory states. In a memory state with `mem_ready`=0:
  - `upc` holds.
  - PCWrite, PCWriteCond, IRWrite and RegWrite are forced to 0.
  - MemRead, MemWrite, IorD and the ALU selects keep their microword values.
- `instr_done`=1 in the following cases:
  - states 4, 7, 8, 9 and 11;
  - state 5 when `mem_ready`=1;
  - state 1 when dispatch-1 yields an illegal opcode;
  - state 2 when dispatch-2 yields an illegal opcode.
- `illegal_op` is a register. Its next value is 1 exactly when a dispatch yields an illegal opcode, otherwise 0. Reset clears it to 0.

## Timing
- Reset:
  - `upc`=0 and `illegal_op`=0 on the first rising edge with `rst`=1.
  - The cycle after `rst` falls shows the FETCH microword.
- Reset mid-instruction: the sequencer abandons the instruction and returns to 0 on the next edge. No partial write-enable is issued during the `rst` cycle.
- All `upc` transitions occur on the rising edge.
- Cycles per instruction with `mem_ready` tied to 1:
  - lw 5 (0-1-2-3-4)
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each cycle with `mem_ready`=0 in a memory state adds exactly one cycle.
- `RegDst` is valid in the same cycle as `RegWrite`, so the downstream mux and register file capture on the edge that ends that state.
- `illegal_op` is high during the FETCH cycle that follows the offending dispatch, for one cycle only.
- `op` is sampled only in states 1 and 2.

## Test plan
- Reset and fetch wait:
  - Stimulus: `rst`=1 for 2 cycles, release, with `mem_ready`=0 for 3 cycles and then 1.
  - Response: `upc` stays 0 for 4 cycles, MemRead=1 throughout, PCWrite=IRWrite=0 for 3 cycles and 1 in the 4th, then `upc`=1.
- lw, `op`=100011, `mem_ready`=1:
  - Response: `upc` sequence 0,1,2,3,4,0.
  - In state 4: RegWrite=1, MemtoReg=1, RegDst=0.
  - `instr_done` is high only in the cycle with `upc`=4.
- R-type, `op`=000000:
  - Response: `upc` sequence 0,1,6,7,0.
  - ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
- sw then beq back-to-back:
  - sw response: `upc` sequence 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5, which holds 2 extra cycles under `mem_ready`=0.
  - beq response: `upc` sequence 0,1,8. PCWriteCond=1 and PCSource=01 in state 8.
- Illegal opcode `op`=111111:
  - Response: `upc` sequence 0,1,0.
  - `instr_done`=1 in state 1; `illegal_op`=1 in the next cycle only; no RegWrite or MemWrite asserted.
- Reset mid-instruction:
  - Stimulus: assert `rst` while `upc`=3 and `mem_ready`=0.
  - Response: all controls are 0 during `rst`, `upc`=0 after the edge, and the FETCH word appears after release.
